// File: rtl/pea_sched_pkg.sv
// ---------------------------------------------------------------------------
// pea_sched_pkg
//   Shared definitions for the PEA firing scheduler:
//   - CFDF mode encodings presented to the PEA actor on next_instr
//   - scheduler state enumeration
//   - ceiling-log2 helper used to size the watchdog counter
// ---------------------------------------------------------------------------
package pea_sched_pkg;

    // CFDF modes understood by PEA_top_module_1 / PEA_enable
    localparam logic [1:0] SETUP_INSTR  = 2'b00;
    localparam logic [1:0] INSTR        = 2'b01;
    localparam logic [1:0] OUTPUT       = 2'b10;
    localparam logic [1:0] ILLEGAL_MODE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_FIRE    = 3'd2,
        S_WAIT_FC = 3'd3,
        S_SETTLE  = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6
    } state_e;

    // Smallest width w (at least 1) such that 2**w >= value
    function automatic int log2ceil(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pea_watchdog.sv
// ---------------------------------------------------------------------------
// pea_watchdog
//   Counts cycles spent waiting for firing-complete. The counter is cleared
//   while the firing pulse is issued and advances once per waiting cycle.
//   expire_o flags the cycle in which the count would reach WDOG_CYCLES-1,
//   so the owner can leave for its error state on that same clock edge.
//
// Ports
//   clk_i     in   1   system clock
//   rst_ni    in   1   asynchronous reset, active-low
//   clear_i   in   1   reset the count to zero on the next edge
//   count_i   in   1   advance the count by one on the next edge
//   expire_o  out  1   count is about to reach WDOG_CYCLES-1
// ---------------------------------------------------------------------------
module pea_watchdog
    import pea_sched_pkg::*;
#(
    parameter int WDOG_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic count_i,
    output logic expire_o
);

    localparam int W = log2ceil(WDOG_CYCLES);
    // Value held on the edge before the limit is reached
    localparam logic [W-1:0] LAST_BEFORE_LIMIT = W'(WDOG_CYCLES - 2);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = count_i && !clear_i && (count_q == LAST_BEFORE_LIMIT);

endmodule

// File: rtl/pea_firing_scheduler.sv
// ---------------------------------------------------------------------------
// pea_firing_scheduler
//   Sequences firings of the PEA actor. It presents the CFDF mode on
//   next_instr, fires (one-cycle invoke) only when PEA_enable reports
//   enable, waits for firing-complete and then adopts the mode the actor
//   requested for its next firing. Provides a saturating firing count,
//   an optional firing limit and a watchdog on the firing duration.
//
// Ports
//   clk_i          in   1      system clock
//   rst_ni         in   1      asynchronous reset, active-low
//   run_i          in   1      level; 1 = scheduler may fire
//   max_firings_i  in   CNT_W  stop after this many firings; 0 = unbounded
//   enable_i       in   1      from PEA_enable for the current next_instr
//   fc_i           in   1      firing-complete from the actor
//   next_mode_i    in   2      actor-requested next mode, valid with fc_i
//   next_instr_o   out  2      mode presented to the actor and PEA_enable
//   invoke_o       out  1      one-cycle firing pulse
//   busy_o         out  1      in FIRE, WAIT_FC or SETTLE
//   done_o         out  1      firing limit reached
//   error_o        out  1      watchdog timeout or illegal mode (sticky)
//   fire_count_o   out  CNT_W  completed firings, saturating
// ---------------------------------------------------------------------------
module pea_firing_scheduler
    import pea_sched_pkg::*;
#(
    parameter int WDOG_CYCLES = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic [CNT_W-1:0] max_firings_i,
    input  logic             enable_i,
    input  logic             fc_i,
    input  logic [1:0]       next_mode_i,
    output logic [1:0]       next_instr_o,
    output logic             invoke_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [CNT_W-1:0] fire_count_o
);

    state_e           state_q, state_d;
    logic [1:0]       next_instr_q, next_instr_d;
    logic             invoke_q, invoke_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] fire_count_q, fire_count_d;

    logic wdogClear;
    logic wdogCount;
    logic wdogExpire;

    // Watchdog control depends only on the current state, keeping the
    // expire path free of any loop back through the next-state logic
    assign wdogClear = (state_q == S_FIRE);
    assign wdogCount = (state_q == S_WAIT_FC);

    pea_watchdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (wdogClear),
        .count_i  (wdogCount),
        .expire_o (wdogExpire)
    );

    // Next-state and registered-output logic. invoke is raised on the edge
    // entering FIRE so it is high for exactly the FIRE cycle. next_instr
    // doubles as the latch for the actor-requested mode, so it only moves
    // on the edge into SETTLE and the actor sees a stable mode throughout
    // CHECK, FIRE and WAIT_FC. fc is looked at only in WAIT_FC, which
    // discards a stale fc left over from an earlier firing.
    always_comb begin
        state_d      = state_q;
        next_instr_d = next_instr_q;
        invoke_d     = 1'b0;
        done_d       = done_q;
        error_d      = error_q;
        fire_count_d = fire_count_q;

        unique case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!run_i) begin
                    state_d = S_IDLE;
                end else if (enable_i) begin
                    state_d  = S_FIRE;
                    invoke_d = 1'b1;
                end
            end
            S_FIRE: begin
                state_d = S_WAIT_FC;
            end
            S_WAIT_FC: begin
                if (fc_i) begin
                    state_d      = S_SETTLE;
                    next_instr_d = next_mode_i;
                    if (fire_count_q != '1) begin
                        fire_count_d = fire_count_q + CNT_W'(1);
                    end
                end else if (wdogExpire) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end
            end
            S_SETTLE: begin
                if (next_instr_q == ILLEGAL_MODE) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end else if ((max_firings_i != '0) && (fire_count_q == max_firings_i)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (run_i) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (!run_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            next_instr_q <= SETUP_INSTR;
            invoke_q     <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            fire_count_q <= '0;
        end else begin
            state_q      <= state_d;
            next_instr_q <= next_instr_d;
            invoke_q     <= invoke_d;
            done_q       <= done_d;
            error_q      <= error_d;
            fire_count_q <= fire_count_d;
        end
    end

    assign busy_o       = (state_q == S_FIRE) || (state_q == S_WAIT_FC) || (state_q == S_SETTLE);
    assign next_instr_o = next_instr_q;
    assign invoke_o     = invoke_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign fire_count_o = fire_count_q;

endmodule

// File: tb/tb_pea_firing_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pea_firing_scheduler
//   Directed bench for pea_firing_scheduler with a 16-cycle watchdog.
//   Inputs change 1 time unit after the rising edge; outputs are read at
//   the same point, so each step() shows the result of one clock edge.
// ---------------------------------------------------------------------------
module tb_pea_firing_scheduler;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rstN;
    logic             run;
    logic [CNT_W-1:0] maxFirings;
    logic             enable;
    logic             fc;
    logic [1:0]       nextMode;
    logic [1:0]       nextInstr;
    logic             invoke;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] fireCount;

    int checkCount  = 0;
    int errorCount  = 0;
    int invokeTotal = 0;
    int base;

    logic [1:0] modeSeq  [4];
    logic [1:0] instrSeq [4];

    pea_firing_scheduler #(
        .WDOG_CYCLES (16),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .run_i         (run),
        .max_firings_i (maxFirings),
        .enable_i      (enable),
        .fc_i          (fc),
        .next_mode_i   (nextMode),
        .next_instr_o  (nextInstr),
        .invoke_o      (invoke),
        .busy_o        (busy),
        .done_o        (done),
        .error_o       (error),
        .fire_count_o  (fireCount)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tally every cycle in which the firing pulse is high
    always @(negedge clk) begin
        if (rstN && invoke) begin
            invokeTotal = invokeTotal + 1;
        end
    end

    // Hard stop so a stuck run still ends
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (observed !== expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic f, input logic [1:0] m);
        run      = r;
        enable   = en;
        fc       = f;
        nextMode = m;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
        maxFirings = '0;
        step();
        step();
        rstN = 1'b1;
    endtask

    // Step until invoke is seen, bounded; a missing pulse is a failed check
    task automatic waitInvoke(input string tag);
        int n;
        n = 0;
        while (invoke !== 1'b1 && n < 40) begin
            step();
            n = n + 1;
        end
        checkOutput(tag, 32'(invoke), 32'd1);
    endtask

    initial begin
        modeSeq[0]  = 2'b01; modeSeq[1]  = 2'b00; modeSeq[2]  = 2'b01; modeSeq[3]  = 2'b10;
        instrSeq[0] = 2'b00; instrSeq[1] = 2'b01; instrSeq[2] = 2'b00; instrSeq[3] = 2'b01;

        rstN       = 1'b0;
        maxFirings = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);

        // Reset values
        #2;
        checkOutput("rst_next_instr", 32'(nextInstr), 32'd0);
        checkOutput("rst_invoke",     32'(invoke),    32'd0);
        checkOutput("rst_busy",       32'(busy),      32'd0);
        checkOutput("rst_done",       32'(done),      32'd0);
        checkOutput("rst_error",      32'(error),     32'd0);
        checkOutput("rst_fire_count", 32'(fireCount), 32'd0);
        step();
        rstN = 1'b1;

        // Single firing, fc five cycles after invoke, run dropped mid-firing
        base = invokeTotal;
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
        step();
        checkOutput("one_check_invoke", 32'(invoke), 32'd0);
        checkOutput("one_check_busy",   32'(busy),   32'd0);
        step();
        checkOutput("one_fire_invoke", 32'(invoke),    32'd1);
        checkOutput("one_fire_busy",   32'(busy),      32'd1);
        checkOutput("one_fire_instr",  32'(nextInstr), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
        repeat (4) step();
        checkOutput("one_wait_instr", 32'(nextInstr), 32'd0);
        checkOutput("one_wait_busy",  32'(busy),      32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b01);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
        checkOutput("one_settle_instr", 32'(nextInstr), 32'd1);
        checkOutput("one_settle_count", 32'(fireCount), 32'd1);
        checkOutput("one_settle_busy",  32'(busy),      32'd1);
        step();
        checkOutput("one_idle_busy", 32'(busy), 32'd0);
        repeat (5) step();
        checkOutput("one_invoke_total", 32'(invokeTotal - base), 32'd1);

        // Asynchronous reset while waiting for fc
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
        waitInvoke("midrst_invoke");
        step();
        step();
        checkOutput("midrst_busy_before", 32'(busy), 32'd1);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("midrst_next_instr", 32'(nextInstr), 32'd0);
        checkOutput("midrst_invoke",     32'(invoke),    32'd0);
        checkOutput("midrst_fire_count", 32'(fireCount), 32'd0);
        checkOutput("midrst_busy",       32'(busy),      32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
        step();
        rstN = 1'b1;

        // GC/STP/GC/EVP sequence with a limit of four firings
        maxFirings = 16'd4;
        base = invokeTotal;
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            waitInvoke("seq_invoke");
            checkOutput("seq_instr_at_invoke", 32'(nextInstr), 32'(instrSeq[i]));
            step();
            step();
            applyStimulus(1'b1, 1'b1, 1'b1, modeSeq[i]);
            step();
            applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
            checkOutput("seq_count", 32'(fireCount), 32'(i + 1));
            checkOutput("seq_mode",  32'(nextInstr), 32'(modeSeq[i]));
        end
        step();
        checkOutput("seq_done", 32'(done), 32'd1);
        repeat (10) step();
        checkOutput("seq_invoke_total", 32'(invokeTotal - base), 32'd4);
        checkOutput("seq_done_hold",    32'(done),      32'd1);
        checkOutput("seq_count_hold",   32'(fireCount), 32'd4);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
        step();
        checkOutput("seq_done_clear", 32'(done),      32'd0);
        checkOutput("seq_count_kept", 32'(fireCount), 32'd4);

        // Starved in CHECK for 50 cycles, then enabled
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
        step();
        base = invokeTotal;
        repeat (50) step();
        checkOutput("starve_invokes", 32'(invokeTotal - base), 32'd0);
        checkOutput("starve_error",   32'(error), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
        step();
        checkOutput("starve_release_invoke", 32'(invoke), 32'd1);

        // Watchdog: no fc after invoke
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
        waitInvoke("wdog_invoke");
        repeat (15) step();
        checkOutput("wdog_error_c15", 32'(error), 32'd0);
        checkOutput("wdog_busy_c15",  32'(busy),  32'd1);
        step();
        checkOutput("wdog_error_c16", 32'(error), 32'd1);
        checkOutput("wdog_busy_c16",  32'(busy),  32'd0);
        base = invokeTotal;
        repeat (20) step();
        checkOutput("wdog_no_invoke",    32'(invokeTotal - base), 32'd0);
        checkOutput("wdog_error_sticky", 32'(error), 32'd1);

        // Stale fc in CHECK is ignored; illegal mode leads to error
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
        step();
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b01);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
        checkOutput("stale_count", 32'(fireCount), 32'd0);
        checkOutput("stale_instr", 32'(nextInstr), 32'd0);
        step();
        checkOutput("stale_count_later", 32'(fireCount), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
        step();
        checkOutput("illegal_invoke", 32'(invoke), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
        step();
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b11);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
        checkOutput("illegal_instr", 32'(nextInstr), 32'd3);
        checkOutput("illegal_count", 32'(fireCount), 32'd1);
        step();
        checkOutput("illegal_error", 32'(error), 32'd1);
        checkOutput("illegal_busy",  32'(busy),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
